// File: rtl/pattern_plotter_pkg.sv
// Shared types and constants for the framebuffer test-pattern plotter.
package pattern_plotter_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] a;
    } pixel_t;

    typedef enum logic [1:0] {
        SOLID    = 2'd0,
        GRADIENT = 2'd1,
        BARS     = 2'd2,
        CHECKER  = 2'd3
    } pattern_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } plotter_state_t;

    // Classic colour bars, left to right.
    localparam pixel_t BAR_COLORS [8] = '{
        32'hFFFFFFFF, 32'hFFFF00FF, 32'h00FFFFFF, 32'h00FF00FF,
        32'hFF00FFFF, 32'hFF0000FF, 32'h0000FFFF, 32'h000000FF
    };

endpackage

// File: rtl/pattern_plotter_pixel.sv
// Combinational pixel generator: selects the pattern colour from pre-computed counters.
module pattern_pixel
    import pattern_plotter_pkg::*;
(
    input  logic [1:0]  mode_i,
    input  logic        x_cell_i,
    input  logic        y_cell_i,
    input  logic [7:0]  ramp_i,
    input  logic [2:0]  bar_i,
    input  logic [31:0] solid_i,
    output logic [31:0] pixel_o
);

    always_comb begin
        pixel_o = '0;
        case (pattern_mode_t'(mode_i))
            SOLID:    pixel_o = solid_i;
            GRADIENT: pixel_o = {4{ramp_i}};
            BARS:     pixel_o = BAR_COLORS[bar_i];
            CHECKER:  pixel_o = (x_cell_i ^ y_cell_i) ? '1 : '0;
            default:  pixel_o = '0;
        endcase
    end

endmodule

// File: rtl/pattern_plotter.sv
// Framebuffer test-pattern source writing one WIDTH x HEIGHT frame per start (or continuously).
// Optional frame-to-frame animation enabled by defining PATTERN_PLOTTER_ANIM_EN.
module pattern_plotter
    import pattern_plotter_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int ADDR_W    = 19,
    parameter int GRAD_MAX  = 200,
    parameter int CELL_LOG2 = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic [1:0]        mode,
    input  logic [31:0]       solid_color,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_address,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count
);

    // Counters are widened so the checker cell bit always exists.
    localparam int XW    = ($clog2(WIDTH)  > CELL_LOG2) ? $clog2(WIDTH)  : CELL_LOG2 + 1;
    localparam int YW    = ($clog2(HEIGHT) > CELL_LOG2) ? $clog2(HEIGHT) : CELL_LOG2 + 1;
    localparam int BAR_W = WIDTH / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    plotter_state_t    state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
    logic [7:0]        ramp_q, ramp_d;
    logic [2:0]        bar_q, bar_d;
    logic [BW-1:0]     bpx_q, bpx_d;
    logic [1:0]        mode_q, mode_d;
    logic [31:0]       solid_q, solid_d;
    logic              done_q, done_d;
    logic [15:0]       count_q, count_d;
    logic [7:0]        phase_q, phase_d;
    logic              load, step, accept, last;
    logic              cell_x;
    logic [31:0]       pix;

    assign accept = valid_q && wr_ready;
    assign last   = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        ramp_d  = ramp_q;
        bar_d   = bar_q;
        bpx_d   = bpx_q;
        mode_d  = mode_q;
        solid_d = solid_q;
        done_d  = 1'b0;
        count_d = count_q;
        phase_d = phase_q;
        load    = 1'b0;
        step    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    if (last) begin
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
`ifdef PATTERN_PLOTTER_ANIM_EN
                        phase_d = (phase_q == 8'(GRAD_MAX - 1)) ? '0 : phase_q + 8'd1;
`endif
                        if (continuous) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            addr_d  = '0;
                            x_d     = '0;
                            y_d     = '0;
                        end
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Counters track the pixel about to be presented; the pixel colour is registered with it.
        if (load) begin
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            valid_d = 1'b1;
            ramp_d  = phase_d;
            bar_d   = phase_d[2:0];
            bpx_d   = '0;
            mode_d  = mode;
            solid_d = solid_color;
        end else if (step) begin
            addr_d = addr_q + 1'b1;
            if (x_q == XW'(WIDTH - 1)) begin
                x_d    = '0;
                y_d    = y_q + 1'b1;
                ramp_d = phase_d;
                bar_d  = phase_d[2:0];
                bpx_d  = '0;
            end else begin
                x_d    = x_q + 1'b1;
                ramp_d = (ramp_q == 8'(GRAD_MAX - 1)) ? '0 : ramp_q + 8'd1;
                if (bpx_q == BW'(BAR_W - 1)) begin
                    bpx_d = '0;
                    bar_d = bar_q + 3'd1;
                end else begin
                    bpx_d = bpx_q + 1'b1;
                end
            end
        end
    end

`ifdef PATTERN_PLOTTER_ANIM_EN
    assign cell_x = x_d[CELL_LOG2] ^ phase_d[0];
`else
    assign cell_x = x_d[CELL_LOG2];
`endif

    pattern_pixel u_pixel (
        .mode_i   (mode_d),
        .x_cell_i (cell_x),
        .y_cell_i (y_d[CELL_LOG2]),
        .ramp_i   (ramp_d),
        .bar_i    (bar_d),
        .solid_i  (solid_d),
        .pixel_o  (pix)
    );

    assign data_d = (load || step) ? pix : data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ramp_q  <= '0;
            bar_q   <= '0;
            bpx_q   <= '0;
            mode_q  <= '0;
            solid_q <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ramp_q  <= ramp_d;
            bar_q   <= bar_d;
            bpx_q   <= bpx_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            done_q  <= done_d;
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign wr_valid    = valid_q;
    assign wr_address  = addr_q;
    assign wr_data     = data_q;
    assign busy        = (state_q == RUN);
    assign frame_done  = done_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_pattern_plotter.sv
// Directed self-checking bench for pattern_plotter on a 16x4 frame.
module tb_pattern_plotter;

    localparam int W  = 16;
    localparam int H  = 4;
    localparam int GM = 5;
    localparam int N  = W * H;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        continuous;
    logic [1:0]  mode;
    logic [31:0] solid_color;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_address;
    logic [31:0] wr_data;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int exp_count = 0;

    int          q_addr [$];
    logic [31:0] q_data [$];
    int          q_cyc  [$];
    int          fd_cyc [$];

    logic [31:0] bars [8] = '{
        32'hFFFFFFFF, 32'hFFFF00FF, 32'h00FFFFFF, 32'h00FF00FF,
        32'hFF00FFFF, 32'hFF0000FF, 32'h0000FFFF, 32'h000000FF
    };

    pattern_plotter #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .ADDR_W    (6),
        .GRAD_MAX  (GM),
        .CELL_LOG2 (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
        .mode        (mode),
        .solid_color (solid_color),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_address  (wr_address),
        .wr_data     (wr_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Logs the accept that the coming edge will perform, then advances one cycle.
    task automatic tick();
        logic        hold;
        logic [5:0]  ha;
        logic [31:0] hd;
        hold = wr_valid && !wr_ready;
        ha   = wr_address;
        hd   = wr_data;
        if (wr_valid && wr_ready) begin
            q_addr.push_back(int'(wr_address));
            q_data.push_back(wr_data);
            q_cyc.push_back(cyc);
        end
        @(posedge clock);
        #1;
        cyc++;
        if (frame_done) fd_cyc.push_back(cyc);
        if (hold) begin
            check("hold_valid", 32'(wr_valid), 32'd1);
            check("hold_addr", 32'(wr_address), 32'(ha));
            check("hold_data", wr_data, hd);
        end
    endtask

    task automatic run_to(input int n, input bit rnd);
        int budget;
        budget = 4000;
        while (q_addr.size() < n && budget > 0) begin
            wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            budget--;
        end
        if (q_addr.size() < n) check("timeout", 32'(q_addr.size()), 32'(n));
        wr_ready = 1'b1;
    endtask

    task automatic clear();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        fd_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic int phase_of(input int done_frames);
`ifdef PATTERN_PLOTTER_ANIM_EN
        return done_frames % GM;
`else
        return 0 * done_frames;
`endif
    endfunction

    function automatic logic [31:0] exp_pix(input int md, input int x, input int y,
                                            input logic [31:0] sol, input int ph);
        int v;
        case (md)
            0: return sol;
            1: begin
                v = (x + ph) % GM;
                return {4{8'(v)}};
            end
            2: return bars[3'((x / 2 + ph) % 8)];
            default: return (x[2] ^ y[2] ^ ph[0]) ? 32'hFFFFFFFF : 32'h0;
        endcase
    endfunction

    task automatic check_frame(input int base, input int md, input logic [31:0] sol,
                               input int ph, input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "_addr"}, 32'(q_addr[base + i]), 32'(i));
            check({tag, "_data"}, q_data[base + i], exp_pix(md, i % W, i / W, sol, ph));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; continuous = 1'b0; mode = 2'd0;
        solid_color = '0; wr_ready = 1'b1;
        #12;
        check("rst_valid", 32'(wr_valid), 32'd0);
        check("rst_addr", 32'(wr_address), 32'd0);
        check("rst_data", wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        reset = 1'b0;
        tick();

        // Single SOLID frame, always ready
        clear();
        mode = 2'd0; solid_color = 32'h11223344;
        pulse_start();
        check("lat_valid", 32'(wr_valid), 32'd1);
        check("lat_addr", 32'(wr_address), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        run_to(N, 1'b0);
        check_frame(0, 0, 32'h11223344, phase_of(exp_count), "solid");
        check("solid_b2b", 32'(q_cyc[N-1] - q_cyc[0]), 32'(N - 1));
        check("solid_ndone", 32'(fd_cyc.size()), 32'd1);
        check("solid_done_t", 32'(fd_cyc[0]), 32'(q_cyc[N-1] + 1));
        exp_count++;
        check("solid_count", 32'(frame_count), 32'(exp_count));
        check("solid_busy", 32'(busy), 32'd0);
        check("solid_valid", 32'(wr_valid), 32'd0);
        tick();
        check("done_pulse", 32'(frame_done), 32'd0);

        // GRADIENT: ramp restarts every line
        clear();
        mode = 2'd1;
        pulse_start();
        run_to(N, 1'b0);
        check_frame(0, 1, 32'h0, phase_of(exp_count), "grad");
`ifdef PATTERN_PLOTTER_ANIM_EN
        check("grad_line1_x0", q_data[W], 32'h01010101);
        check("grad_x4", q_data[4], 32'h00000000);
`else
        check("grad_line1_x0", q_data[W], 32'h00000000);
        check("grad_x5", q_data[5], 32'h00000000);
        check("grad_x4", q_data[4], 32'h04040404);
`endif
        exp_count++;
        check("grad_count", 32'(frame_count), 32'(exp_count));

        // CHECKER with random stalls, then a second frame
        for (int f = 0; f < 2; f++) begin
            clear();
            mode = 2'd3;
            pulse_start();
            run_to(N, f == 0);
            check_frame(0, 3, 32'h0, phase_of(exp_count), "chk");
            check("chk_ndone", 32'(fd_cyc.size()), 32'd1);
            exp_count++;
            check("chk_count", 32'(frame_count), 32'(exp_count));
        end

        // Continuous BARS, continuous dropped mid third frame
        clear();
        mode = 2'd2; continuous = 1'b1;
        pulse_start();
        run_to(2 * N, 1'b0);
        check_frame(0, 2, 32'h0, phase_of(exp_count), "bars0");
        check_frame(N, 2, 32'h0, phase_of(exp_count + 1), "bars1");
        check("bars_nobubble", 32'(q_cyc[N] - q_cyc[N-1]), 32'd1);
        exp_count += 2;
        check("bars_count2", 32'(frame_count), 32'(exp_count));
        run_to(2 * N + 10, 1'b0);
        continuous = 1'b0;
        run_to(3 * N, 1'b0);
        check_frame(2 * N, 2, 32'h0, phase_of(exp_count), "bars2");
        exp_count++;
        check("bars_count3", 32'(frame_count), 32'(exp_count));
        check("bars_busy", 32'(busy), 32'd0);
        tick(); tick();
        check("bars_valid", 32'(wr_valid), 32'd0);
        check("bars_nacc", 32'(q_addr.size()), 32'(3 * N));
        check("bars_ndone", 32'(fd_cyc.size()), 32'd3);

        // Start and mode change mid-frame are ignored
        clear();
        mode = 2'd0; solid_color = 32'hA5A5A5A5;
        pulse_start();
        run_to(20, 1'b0);
        check("ign_at20", 32'(wr_address), 32'd20);
        pulse_start();
        run_to(30, 1'b0);
        mode = 2'd3; solid_color = 32'h0;
        run_to(N, 1'b0);
        check_frame(0, 0, 32'hA5A5A5A5, phase_of(exp_count), "ign");
        exp_count++;
        repeat (3) tick();
        check("ign_busy", 32'(busy), 32'd0);
        check("ign_nacc", 32'(q_addr.size()), 32'(N));
        check("ign_count", 32'(frame_count), 32'(exp_count));

        // Asynchronous reset mid-frame
        clear();
        mode = 2'd2;
        pulse_start();
        run_to(40, 1'b0);
        check("rst_at40", 32'(wr_address), 32'd40);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(wr_valid), 32'd0);
        check("mid_rst_count", 32'(frame_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addr", 32'(wr_address), 32'd0);
        #1 reset = 1'b0;
        exp_count = 0;
        clear();
        tick(); tick();
        check("post_rst_valid", 32'(wr_valid), 32'd0);
        check("post_rst_ndone", 32'(fd_cyc.size()), 32'd0);
        mode = 2'd0; solid_color = 32'h11223344;
        pulse_start();
        check("post_rst_addr", 32'(wr_address), 32'd0);
        check("post_rst_v", 32'(wr_valid), 32'd1);
        run_to(N, 1'b0);
        check_frame(0, 0, 32'h11223344, phase_of(exp_count), "post");
        exp_count++;
        check("post_count", 32'(frame_count), 32'(exp_count));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
